vram_scanout: RTL and testbench
===============================

# vram_scanout

Display-side reader for the 16x16 one-bit video RAM. It generates 640x480@60 VGA timing from the pixel clock, scans the RAM cell by cell, and drives hsync, vsync, de and pixel through a latency-matched pipeline. The RAM has a single x/y address port, so this block owns that port. It multiplexes game-logic write requests onto the port only during blanking, using a req/ack handshake.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths (H_TOTAL = 800)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths (V_TOTAL = 525)
- CELL_W, 40, pixels per cell horizontally; 16*CELL_W must equal H_ACTIVE
- CELL_H, 30, lines per cell vertically; 16*CELL_H must equal V_ACTIVE

Ports:
- clk  in  1  pixel clock (25 MHz nominal)
- rst_n  in  1  asynchronous, active-low reset
- ram_x, ram_y  out  4 each  RAM cell address, registered
- ram_we  out  1  RAM write enable, registered
- ram_wdata  out  1  RAM write data, registered
- ram_rdata  in  1  RAM registered read data
- wr_req  in  1  write request from game logic; held until wr_ack
- wr_x, wr_y  in  4 each  write cell address; stable while wr_req is high
- wr_data  in  1  write data; stable while wr_req is high
- wr_ack  out  1  one-cycle pulse marking the cycle the write is presented to the RAM
- hsync, vsync  out  1 each  active-low sync pulses
- de  out  1  display enable (visible region)
- pixel  out  1  pixel value; forced to 0 when de is 0
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0)

## Operation
- Counters: h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps, running 0..V_TOTAL-1.
- Visible region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Blank is the complement of the visible region.
- Cell indices: cx and cy come from sub-counters; no division is used.
  - cx_sub counts 0..CELL_W-1 during visible pixels; on wrap, cx increments.
  - cx and cx_sub clear at end of line.
  - cy_sub and cy advance at end of each visible line and clear at end of frame.
- Address mux, evaluated at each edge:
  - If the counter is in the visible region: ram_x/ram_y <= cx/cy, ram_we <= 0.
  - Else, if wr_req=1 and wr_ack=0: ram_x/ram_y <= wr_x/wr_y, ram_wdata <= wr_data, ram_we <= 1, wr_ack <= 1.
  - Otherwise: ram_we <= 0, wr_ack <= 0, address holds.
- Handshake rules:
  - The write and wr_ack occur in the same cycle.
  - The requester may change data or drop wr_req on the following edge.
  - The wr_ack=0 guard limits writes to at most one per two cycles and prevents double writes.
  - A request pending at blank end waits for the next blank; this covers both horizontal and vertical blanking.
- Sync decode:
  - hsync = 0 for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync = 0 for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).

## Timing
- Pipeline latency is 3 cycles from counter to output, with every video output aligned:
  - t: counter state.
  - t+1: ram_x/ram_y registered.
  - t+2: RAM ram_rdata valid.
  - t+3: pixel, de, hsync, vsync and frame_start registered.
- hsync, vsync and de pass through 3-stage delay lines. pixel <= de_d2 & ram_rdata.
- Reset values: hsync=1, vsync=1, de=0, pixel=0, frame_start=0, ram_we=0, ram_wdata=0, wr_ack=0, ram_x=0, ram_y=0. All counters and delay stages are 0 (sync stages 1).
- Reset mid-frame or mid-write:
  - An in-flight write is dropped with no ack.
  - After release, the first frame restarts at counter (0,0).
  - The first frame_start occurs 3 cycles after the first post-reset edge.
- A write can never coincide with a visible-region address, so no read is ever corrupted.

## Structure
- Shared package vga_timing_pkg holds:
  - the timing defaults and derived H_TOTAL/V_TOTAL constants;
  - the sync polarity constant;
  - the 4-bit cell-coordinate typedef.
- Sub-module vga_timing_gen contains h/v counters, the visible and blank flags, and raw sync decode.
- vram_scanout instantiates it and adds the cell counters, address/write mux, handshake and output pipeline.

## Test plan
- Reset, then free-run one frame:
  - hsync low for exactly 96 cycles per 800-cycle line;
  - vsync low for 2 lines per 525-line frame;
  - de high 640 cycles per line on 480 lines;
  - frame_start every 420000 cycles.
- RAM model with cell (3,5)=1, others 0: pixel=1 only for output x 120..159 and y 150..179.
- wr_req with (7,9,1) asserted mid-visible-line: no ram_we until h_cnt=640; then a single ram_we/wr_ack pulse with ram_x=7, ram_y=9; no second write while wr_req is held high.
- Back-to-back requests during vertical blank: writes land every 2 cycles; each wr_ack is one cycle wide.
- Write cell (0,0)=1 during blank: on the next frame, pixel=1 for exactly the first 40 pixels of lines 0..29.
- Assert rst_n low mid-line with wr_req pending: all outputs take their reset values immediately; no ack; after release, timing restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, sync polarity and the 4-bit RAM cell coordinate type.
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned DEF_CELL_W = 40;
  localparam int unsigned DEF_CELL_H = 30;

  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int unsigned CELL_BITS = 4;
  typedef logic [CELL_BITS-1:0] cell_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with visible/blank flags and raw (undelayed) sync decode.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic clk,
  input  logic rst_n,
  output logic visible_c_o,
  output logic blank_c_o,
  output logic v_active_c_o,
  output logic line_end_c_o,
  output logic frame_end_c_o,
  output logic origin_c_o,
  output logic hsync_raw_c_o,
  output logic vsync_raw_c_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  assign line_end_c_o  = (h_cnt_q == HW'(H_TOTAL - 1));
  assign frame_end_c_o = line_end_c_o && (v_cnt_q == VW'(V_TOTAL - 1));
  assign v_active_c_o  = (v_cnt_q < VW'(V_ACTIVE));
  assign visible_c_o   = (h_cnt_q < HW'(H_ACTIVE)) && v_active_c_o;
  assign blank_c_o     = ~visible_c_o;
  assign origin_c_o    = (h_cnt_q == '0) && (v_cnt_q == '0);

  assign hsync_raw_c_o = ((h_cnt_q >= HW'(H_ACTIVE + H_FP)) &&
                          (h_cnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_raw_c_o = ((v_cnt_q >= VW'(V_ACTIVE + V_FP)) &&
                          (v_cnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  // v advances only on the h wrap
  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (line_end_c_o) begin
      h_cnt_d = '0;
      v_cnt_d = frame_end_c_o ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

endmodule

// File: rtl/vram_scanout.sv
// Scans the 16x16 one-bit video RAM onto VGA timing and slots game-logic writes into blanking.
module vram_scanout
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned CELL_W   = DEF_CELL_W,
  parameter int unsigned CELL_H   = DEF_CELL_H
) (
  input  logic  clk,
  input  logic  rst_n,
  output cell_t ram_x,
  output cell_t ram_y,
  output logic  ram_we,
  output logic  ram_wdata,
  input  logic  ram_rdata,
  input  logic  wr_req,
  input  cell_t wr_x,
  input  cell_t wr_y,
  input  logic  wr_data,
  output logic  wr_ack,
  output logic  hsync,
  output logic  vsync,
  output logic  de,
  output logic  pixel,
  output logic  frame_start
);

  localparam int unsigned CXW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int unsigned CYW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  logic visible, blank, v_active, line_end, frame_end, origin, hsync_raw, vsync_raw;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk           (clk),
    .rst_n         (rst_n),
    .visible_c_o   (visible),
    .blank_c_o     (blank),
    .v_active_c_o  (v_active),
    .line_end_c_o  (line_end),
    .frame_end_c_o (frame_end),
    .origin_c_o    (origin),
    .hsync_raw_c_o (hsync_raw),
    .vsync_raw_c_o (vsync_raw)
  );

  logic [CXW-1:0] cx_sub_q, cx_sub_d;
  logic [CYW-1:0] cy_sub_q, cy_sub_d;
  cell_t          cx_q, cx_d, cy_q, cy_d;
  cell_t          ram_x_q, ram_x_d, ram_y_q, ram_y_d;
  logic           ram_we_q, ram_we_d, ram_wdata_q, ram_wdata_d, wr_ack_q, wr_ack_d;
  logic [2:0]     de_pipe_q, de_pipe_d, hs_pipe_q, hs_pipe_d, vs_pipe_q, vs_pipe_d, fs_pipe_q, fs_pipe_d;
  logic           pixel_q, pixel_d;

  // Cell indices track the counter position without division
  always_comb begin
    cx_sub_d = cx_sub_q;
    cx_d     = cx_q;
    cy_sub_d = cy_sub_q;
    cy_d     = cy_q;
    if (visible) begin
      if (cx_sub_q == CXW'(CELL_W - 1)) begin
        cx_sub_d = '0;
        cx_d     = cx_q + cell_t'(1);
      end else begin
        cx_sub_d = cx_sub_q + CXW'(1);
      end
    end
    if (line_end) begin
      cx_sub_d = '0;
      cx_d     = '0;
      if (v_active) begin
        if (cy_sub_q == CYW'(CELL_H - 1)) begin
          cy_sub_d = '0;
          cy_d     = cy_q + cell_t'(1);
        end else begin
          cy_sub_d = cy_sub_q + CYW'(1);
        end
      end
    end
    if (frame_end) begin
      cy_sub_d = '0;
      cy_d     = '0;
    end
  end

  // RAM port owner: scan address when visible, one write per grant during blank
  always_comb begin
    ram_x_d     = ram_x_q;
    ram_y_d     = ram_y_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    if (visible) begin
      ram_x_d = cx_q;
      ram_y_d = cy_q;
    end else if (blank && wr_req && !wr_ack_q) begin
      ram_x_d     = wr_x;
      ram_y_d     = wr_y;
      ram_wdata_d = wr_data;
      ram_we_d    = 1'b1;
      wr_ack_d    = 1'b1;
    end
  end

  // Video delay lines matched to the address + RAM read latency
  always_comb begin
    de_pipe_d = {de_pipe_q[1:0], visible};
    hs_pipe_d = {hs_pipe_q[1:0], hsync_raw};
    vs_pipe_d = {vs_pipe_q[1:0], vsync_raw};
    fs_pipe_d = {fs_pipe_q[1:0], origin};
    pixel_d   = de_pipe_q[1] & ram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_sub_q    <= '0;
      cx_q        <= '0;
      cy_sub_q    <= '0;
      cy_q        <= '0;
      ram_x_q     <= '0;
      ram_y_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      de_pipe_q   <= '0;
      hs_pipe_q   <= {3{~SYNC_ACTIVE}};
      vs_pipe_q   <= {3{~SYNC_ACTIVE}};
      fs_pipe_q   <= '0;
      pixel_q     <= 1'b0;
    end else begin
      cx_sub_q    <= cx_sub_d;
      cx_q        <= cx_d;
      cy_sub_q    <= cy_sub_d;
      cy_q        <= cy_d;
      ram_x_q     <= ram_x_d;
      ram_y_q     <= ram_y_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wr_ack_q    <= wr_ack_d;
      de_pipe_q   <= de_pipe_d;
      hs_pipe_q   <= hs_pipe_d;
      vs_pipe_q   <= vs_pipe_d;
      fs_pipe_q   <= fs_pipe_d;
      pixel_q     <= pixel_d;
    end
  end

  assign ram_x       = ram_x_q;
  assign ram_y       = ram_y_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign wr_ack      = wr_ack_q;
  assign de          = de_pipe_q[2];
  assign hsync       = hs_pipe_q[2];
  assign vsync       = vs_pipe_q[2];
  assign frame_start = fs_pipe_q[2];
  assign pixel       = pixel_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout on a shrunken raster, with a registered-read RAM model.
`timescale 1ns/1ps
module tb_vram_scanout;

  localparam int HA = 64, HFP = 2, HS = 4, HBP = 4, HT = HA + HFP + HS + HBP;
  localparam int VA = 32, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
  localparam int CW = HA / 16, CH = VA / 16;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [3:0] ram_x, ram_y, wr_x, wr_y;
  logic       ram_we, ram_wdata, ram_rdata, wr_req, wr_data, wr_ack;
  logic       hsync, vsync, de, pixel, frame_start;

  vram_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CELL_W(CW), .CELL_H(CH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_x(ram_x), .ram_y(ram_y), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
    .hsync(hsync), .vsync(vsync), .de(de), .pixel(pixel), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int d; int q;} wr_t;
  wr_t  exp_q[$];
  wr_t  commit_q[$];
  int   compared = 0, mismatched = 0;
  int   pos = 0;
  int   last_wr = -10;
  logic ram_mem [16][16];
  logic ref_mem [16][16];

  // Environment RAM: registered read, one write port
  initial begin
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        ram_mem[i][j] = 1'b0;
        ref_mem[i][j] = 1'b0;
      end
    ram_mem[3][5] = 1'b1;
    ref_mem[3][5] = 1'b1;
    ram_rdata = 1'b0;
  end

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_x][ram_y] <= ram_wdata;
    ram_rdata <= ram_mem[ram_x][ram_y];
  end

  // Raster position of the counter during the current cycle
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pos <= 0;
    else        pos <= pos + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, req, pos);
    end
  endtask

  function automatic bit is_blank(input int p);
    return !(((p % HT) < HA) && (((p / HT) % VT) < VA));
  endfunction

  // {hsync, vsync, de, pixel, frame_start} for raster position p
  function automatic logic [4:0] exp_video(input int p);
    int h, v;
    logic d, px;
    if (p < 0) return 5'b11000;
    h  = p % HT;
    v  = (p / HT) % VT;
    d  = (h < HA) && (v < VA);
    px = 1'b0;
    if (d) px = ref_mem[h / CW][v / CH];
    return {!(h >= HA + HFP && h < HA + HFP + HS), !(v >= VA + VFP && v < VA + VFP + VS),
            d, px, (h == 0 && v == 0)};
  endfunction

  int   mon_p;
  logic mon_ack;
  wr_t  mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_p = pos - 3;
      while (commit_q.size() > 0 && commit_q[0].q < mon_p) begin
        ref_mem[commit_q[0].x][commit_q[0].y] = 1'(commit_q[0].d);
        void'(commit_q.pop_front());
      end
      check("video", 32'({hsync, vsync, de, pixel, frame_start}), 32'(exp_video(mon_p)));
      while (exp_q.size() > 0 && exp_q[0].q < pos - 1) begin
        compared++; mismatched++;
        $display("FAIL missed_write: no ack for (%0d,%0d) expected at pos %0d", exp_q[0].x, exp_q[0].y, exp_q[0].q + 1);
        void'(exp_q.pop_front());
      end
      mon_ack = (exp_q.size() > 0) && (exp_q[0].q == pos - 1);
      check("wr_ack", 32'(wr_ack), 32'(mon_ack));
      check("ram_we", 32'(ram_we), 32'(mon_ack));
      if (mon_ack) begin
        mon_e = exp_q.pop_front();
        check("wr_addr_data", 32'({ram_x, ram_y, ram_wdata}), 32'({4'(mon_e.x), 4'(mon_e.y), 1'(mon_e.d)}));
      end
    end else begin
      // Acked writes are in the RAM; anything unacked is dropped by reset
      while (commit_q.size() > 0) begin
        ref_mem[commit_q[0].x][commit_q[0].y] = 1'(commit_q[0].d);
        void'(commit_q.pop_front());
      end
      exp_q.delete();
    end
  end

  task automatic check_reset(input string name);
    check(name, 32'({hsync, vsync, de, pixel, frame_start, ram_we, ram_wdata, wr_ack, ram_x, ram_y}),
          32'({5'b11000, 3'b000, 8'h00}));
  endtask

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!((pos % HT) == h && ((pos / HT) % VT) == v) && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!((pos % HT) == h && ((pos / HT) % VT) == v)) begin
      compared++; mismatched++;
      $display("FAIL wait_hv: raster (%0d,%0d) not reached, got (%0d,%0d)", h, v, pos % HT, (pos / HT) % VT);
    end
  endtask

  // Issue one request at a negedge; the grant lands at the first blank cycle clear of the last grant
  task automatic do_write(input int x, input int y, input int d, input bit drop);
    wr_t e;
    int  q, n;
    wr_x = 4'(x); wr_y = 4'(y); wr_data = 1'(d); wr_req = 1'b1;
    q = (pos > last_wr + 2) ? pos : last_wr + 2;
    while (!is_blank(q)) q++;
    e = '{x, y, d, q};
    exp_q.push_back(e);
    commit_q.push_back(e);
    last_wr = q;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wr_ack && n < 2 * FRAME);
    if (!wr_ack) begin
      compared++; mismatched++;
      $display("FAIL ack_timeout: no wr_ack for (%0d,%0d) got 0 required 1", x, y);
    end
    if (drop) wr_req = 1'b0;
  endtask

  initial begin
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_init");
    rst_n = 1'b1;
    repeat (FRAME + 100) @(negedge clk);

    // Mid-visible request waits for horizontal blank
    wait_hv(HA / 2, 5);
    do_write(7, 9, 1, 1'b1);

    // Back-to-back grants during vertical blank
    wait_hv(0, VA + 1);
    do_write(0, 0, 1, 1'b0);
    do_write(15, 15, 1, 1'b0);
    do_write(3, 5, 0, 1'b0);
    do_write(8, 2, 1, 1'b1);
    repeat (FRAME) @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 200)) @(negedge clk);
      do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b1);
    end
    repeat (FRAME + 10) @(negedge clk);

    // Reset mid-line while a request is pending
    wait_hv(10, 4);
    wr_x = 4'd5; wr_y = 4'd6; wr_data = 1'b1; wr_req = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    wr_req = 1'b0;
    last_wr = -10;
    repeat (3) @(negedge clk);
    check_reset("reset_hold");
    rst_n = 1'b1;
    repeat (FRAME + 50) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clk);
      do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b1);
    end
    repeat (FRAME + 10) @(negedge clk);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
